kl8_tty: RTL and testbench
==========================

# kl8_tty

Console teletype controller, PDP-8/KL8E style: the CPU-side end of the serial console. It decodes IOT instructions for the keyboard (device 03) and printer (device 04), and holds the keyboard buffer and both device flags. It drives the byte-level `uart_tx` handshake and consumes the `uart_rx` strobe. It sits between the CPU IOT bus and the UART pair, and raises the console interrupt request.

## Interface
- `KBD_DEV`, 6'o03: keyboard device code.
- `TTY_DEV`, 6'o04: printer device code.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `iot` in 1: one-cycle strobe; `mb` holds a 6xxx IOT in this cycle.
- `mb` in 12: instruction word; [8:3] device, [2:0] op bits.
- `ac_in` in 12: current AC.
- `ac_clr` out 1: clear AC this cycle.
- `ac_or` out 12: value ORed into AC this cycle; 0 when not reading.
- `skip` out 1: skip the next instruction.
- `irq` out 1: interrupt request, level.
- `rx_data` in 8: received byte.
- `rx_strobe` in 1: one-cycle pulse; `rx_data` valid.
- `tx_data` out 8: byte to transmit.
- `tx_strobe` out 1: one-cycle transmit request.
- `tx_ready` in 1: transmitter idle.

## Operation
- State:
  - `kbuf[7:0]`
  - `kflag`
  - `pflag`
  - `ie`
  - tx FSM: `T_IDLE`, `T_LAUNCH`, `T_BUSY`, `T_DONE`
- Reset values: `kbuf`=0, `kflag`=0, `pflag`=0, `ie`=1, FSM=`T_IDLE`, `tx_data`=0, `tx_strobe`=0.
- Combinational outputs `skip`, `ac_clr` and `ac_or` are 0 whenever `iot`=0 or the device code does not match.
- Keyboard decode, `mb[8:3]==KBD_DEV`:
  - op 0, KCF: clear `kflag`.
  - op 1, KSF: `skip`=`kflag`.
  - op 2, KCC: `ac_clr`=1; clear `kflag`.
  - op 4, KRS: `ac_or`={4'b0,`kbuf`}.
  - op 5, KIE: `ie`<=`ac_in[0]`.
  - op 6, KRB: `ac_clr`=1, `ac_or`={4'b0,`kbuf`}; clear `kflag`.
- Printer decode, `mb[8:3]==TTY_DEV`:
  - op 0, TFL: set `pflag`.
  - op 1, TSF: `skip`=`pflag`.
  - op 2, TCF: clear `pflag`.
  - op 4, TPC: start print of `ac_in[7:0]`.
  - op 5, TSK: `skip`=`kflag`|`pflag`.
  - op 6, TLS: clear `pflag` and start print.
  - ops 3 and 7: NOP.
- Receive: on `rx_strobe`, `kbuf`<=`rx_data` and `kflag`<=1. An unread byte is overwritten (overrun; no error flag).
- Start print:
  - In `T_IDLE`: latch `tx_data`<=`ac_in[7:0]`, go to `T_LAUNCH`.
  - In any other state: the request is ignored and the character is dropped.
- TX FSM:
  - `T_LAUNCH`: `tx_strobe`=1 for exactly one cycle, then `T_BUSY`.
  - `T_BUSY`: wait for `tx_ready`=0, then `T_DONE`.
  - `T_DONE`: wait for `tx_ready`=1, then set `pflag` and go to `T_IDLE`.
- `irq`=`ie` & (`kflag` | `pflag`).

## Timing
- Decode outputs (`skip`, `ac_clr`, `ac_or`) are combinational in the `iot` cycle. Flag, `ie` and `kbuf` updates take effect at the clock edge ending that cycle.
- Simultaneous `rx_strobe` and a kflag-clearing IOT (KCF/KCC/KRB): the set wins, so `kflag`=1 and `kbuf`=new byte. KRB still returns the old `kbuf` in that cycle.
- Simultaneous TFL or done-set and a TCF/TLS clear on `pflag`: the set wins.
- `tx_strobe` is asserted 1 cycle after the TPC/TLS cycle.
- `pflag` rises 1 cycle after `tx_ready` returns high.
- Minimum print-to-flag time is the `uart_tx` frame time plus 3 cycles.
- `rst_n` low mid-transmit: the FSM returns to `T_IDLE` at once. Any in-flight `uart_tx` frame completes on its own; `pflag` stays 0.

## Configuration
- `KL8_IE_EN` defined:
  - KIE (op 5, keyboard) and TSK (op 5, printer) are implemented as above.
  - `irq` is gated by `ie`.
- `KL8_IE_EN` undefined:
  - `ie` is constant 1.
  - KIE and TSK are NOPs (no skip, no AC effect).
  - `irq`=`kflag`|`pflag`.

## Test plan
- Reset, then IOT 6031 → `skip`=0, `irq`=0. Pulse `rx_strobe` with 8'h41, then 6031 → `skip`=1. Then 6036 → `ac_clr`=1, `ac_or`=12'o0101, and `kflag`=0 afterwards.
- `ac_in`=12'o0215, IOT 6046 → `tx_strobe` 1 cycle later with `tx_data`=8'h8D. Model `tx_ready` low for 100 cycles → `pflag` rises 1 cycle after `tx_ready` goes high; 6041 then returns `skip`=1.
- Second 6044 while FSM is in `T_BUSY` → no second `tx_strobe`; `tx_data` unchanged.
- `rx_strobe` with 8'h55 in the same cycle as 6036 → `ac_or` carries the old byte, `kflag`=1 afterwards, and `kbuf`=8'h55.
- With `KL8_IE_EN`: `ac_in`=0, 6035, then receive a byte → `irq`=0. 6035 with `ac_in`=1 → `irq`=1. 6045 → `skip`=1.
- Assert `rst_n` low in `T_BUSY` → FSM=`T_IDLE`, all flags 0, `ie`=1. The next 6046 transmits normally.

Source files
------------

// File: rtl/kl8_tty.sv
// kl8_tty: PDP-8 KL8E-style console teletype controller.
// Decodes keyboard (device 03) and printer (device 04) IOTs, holds the keyboard
// buffer, both device flags and the console interrupt enable, and drives the
// byte-level transmit handshake.
// Optional feature macro: KL8_IE_EN enables KIE/TSK and the interrupt-enable gate.
module kl8_tty #(
    parameter logic [5:0] KBD_DEV = 6'o03,
    parameter logic [5:0] TTY_DEV = 6'o04
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iot,
    input  logic [11:0] mb,
    input  logic [11:0] ac_in,
    output logic        ac_clr,
    output logic [11:0] ac_or,
    output logic        skip,
    output logic        irq,
    input  logic [7:0]  rx_data,
    input  logic        rx_strobe,
    output logic [7:0]  tx_data,
    output logic        tx_strobe,
    input  logic        tx_ready
);

    typedef enum logic [1:0] {TIdle, TLaunch, TBusy, TDone} tx_state_e;

    tx_state_e  tx_q, tx_d;
    logic [7:0] kbuf;
    logic       kflag;
    logic       pflag;
    logic       ie;
    logic       tx_done;

    logic       kbd_sel, tty_sel;
    logic [2:0] op;

    assign op      = mb[2:0];
    assign kbd_sel = iot && (mb[8:3] == KBD_DEV);
    assign tty_sel = iot && (mb[8:3] == TTY_DEV);

    // Keyboard ops
    logic k_kcf, k_ksf, k_kcc, k_krs, k_kie, k_krb;
    assign k_kcf = kbd_sel && (op == 3'd0);
    assign k_ksf = kbd_sel && (op == 3'd1);
    assign k_kcc = kbd_sel && (op == 3'd2);
    assign k_krs = kbd_sel && (op == 3'd4);
    assign k_krb = kbd_sel && (op == 3'd6);

    // Printer ops
    logic t_tfl, t_tsf, t_tcf, t_tpc, t_tsk, t_tls;
    assign t_tfl = tty_sel && (op == 3'd0);
    assign t_tsf = tty_sel && (op == 3'd1);
    assign t_tcf = tty_sel && (op == 3'd2);
    assign t_tpc = tty_sel && (op == 3'd4);
    assign t_tls = tty_sel && (op == 3'd6);

`ifdef KL8_IE_EN
    assign k_kie = kbd_sel && (op == 3'd5);
    assign t_tsk = tty_sel && (op == 3'd5);

    // Interrupt enable, loaded from AC bit 0 by KIE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie <= 1'b1;
        end else if (k_kie) begin
            ie <= ac_in[0];
        end
    end
`else
    assign k_kie = 1'b0;
    assign t_tsk = 1'b0;
    assign ie    = 1'b1;
`endif

    logic print_req, kflag_clr, pflag_set, pflag_clr;
    assign print_req = t_tpc | t_tls;
    assign kflag_clr = k_kcf | k_kcc | k_krb;
    assign pflag_set = t_tfl | tx_done;
    assign pflag_clr = t_tcf | t_tls;

    // Decode outputs are combinational in the IOT cycle
    always_comb begin
        skip   = (k_ksf & kflag) | (t_tsf & pflag) | (t_tsk & (kflag | pflag));
        ac_clr = k_kcc | k_krb;
        ac_or  = (k_krs | k_krb) ? {4'b0, kbuf} : 12'b0;
        irq    = ie & (kflag | pflag);
    end

    // Keyboard buffer and device flags; a set always beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbuf  <= 8'h00;
            kflag <= 1'b0;
            pflag <= 1'b0;
        end else begin
            if (rx_strobe) begin
                kbuf  <= rx_data;
                kflag <= 1'b1;
            end else if (kflag_clr) begin
                kflag <= 1'b0;
            end
            if (pflag_set) begin
                pflag <= 1'b1;
            end else if (pflag_clr) begin
                pflag <= 1'b0;
            end
        end
    end

    // Transmit byte is captured only when the transmitter is free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data <= 8'h00;
        end else if ((tx_q == TIdle) && print_req) begin
            tx_data <= ac_in[7:0];
        end
    end

    // TX FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= TIdle;
        end else begin
            tx_q <= tx_d;
        end
    end

    // TX FSM next state; prints requested while not idle are dropped
    always_comb begin
        tx_d      = tx_q;
        tx_strobe = 1'b0;
        tx_done   = 1'b0;
        unique case (tx_q)
            TIdle:   if (print_req) tx_d = TLaunch;
            TLaunch: begin
                tx_strobe = 1'b1;
                tx_d      = TBusy;
            end
            TBusy:   if (!tx_ready) tx_d = TDone;
            TDone: begin
                if (tx_ready) begin
                    tx_done = 1'b1;
                    tx_d    = TIdle;
                end
            end
            default: tx_d = TIdle;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{mb[11:9], ac_in[11:8], ac_in[0], k_kie};

endmodule

// File: tb/tb_kl8_tty.sv
// tb_kl8_tty: randomized and directed checks of kl8_tty against a cycle-level
// behavioural model of the console (flags, buffer, one print in flight).
module tb_kl8_tty;

`ifdef KL8_IE_EN
    localparam bit IeEn = 1'b1;
`else
    localparam bit IeEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iot = 1'b0;
    logic [11:0] mb = 12'o0;
    logic [11:0] ac_in = 12'o0;
    logic        ac_clr;
    logic [11:0] ac_or;
    logic        skip;
    logic        irq;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_strobe = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_strobe;
    logic        tx_ready = 1'b1;

    kl8_tty dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iot       (iot),
        .mb        (mb),
        .ac_in     (ac_in),
        .ac_clr    (ac_clr),
        .ac_or     (ac_or),
        .skip      (skip),
        .irq       (irq),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe),
        .tx_data   (tx_data),
        .tx_strobe (tx_strobe),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] m_kbuf;
    bit         m_kflag, m_pflag, m_ie;
    bit         m_busy, m_low;
    int         m_launch;
    logic [7:0] m_txdata;
    int         cyc = 0;

    // Simple UART responder
    int uart_cnt = 0;
    int frame_len = 5;
    bit rand_frame = 1'b0;

    // Last observed outputs
    logic       o_skip, o_clr, o_strobe, o_irq, o_ready;
    logic [11:0] o_or;
    logic [7:0] o_txdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_kbuf   = 8'h00;
        m_kflag  = 1'b0;
        m_pflag  = 1'b0;
        m_ie     = 1'b1;
        m_busy   = 1'b0;
        m_low    = 1'b0;
        m_launch = 0;
        m_txdata = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        iot       = 1'b0;
        rx_strobe = 1'b0;
        #1;
        model_reset();
        check_eq("rst_strobe", tx_strobe, 1'b0);
        check_eq("rst_irq", irq, 1'b0);
        check_eq("rst_txdata", tx_data, 8'h00);
        check_eq("rst_skip", skip, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive, check against model, advance model
    task automatic step(input logic s_iot, input logic [11:0] s_mb, input logic [11:0] s_ac,
                        input logic s_rx, input logic [7:0] s_rxd);
        bit         kd, pd, done, start;
        logic [2:0] op;
        bit         e_skip, e_clr, e_strobe, e_irq;
        logic [11:0] e_or;
        @(negedge clk);
        iot       = s_iot;
        mb        = s_mb;
        ac_in     = s_ac;
        rx_strobe = s_rx;
        rx_data   = s_rxd;
        tx_ready  = (uart_cnt == 0);
        #1;
        kd = s_iot && (s_mb[8:3] == 6'o03);
        pd = s_iot && (s_mb[8:3] == 6'o04);
        op = s_mb[2:0];
        e_skip = (kd && op == 3'd1 && m_kflag) || (pd && op == 3'd1 && m_pflag) ||
                 (IeEn && pd && op == 3'd5 && (m_kflag || m_pflag));
        e_clr = kd && (op == 3'd2 || op == 3'd6);
        e_or = (kd && (op == 3'd4 || op == 3'd6)) ? {4'b0, m_kbuf} : 12'o0;
        e_strobe = m_busy && (cyc == m_launch + 1);
        e_irq = m_ie && (m_kflag || m_pflag);
        check_eq("skip", skip, e_skip);
        check_eq("ac_clr", ac_clr, e_clr);
        check_eq("ac_or", ac_or, e_or);
        check_eq("tx_strobe", tx_strobe, e_strobe);
        check_eq("tx_data", tx_data, m_txdata);
        check_eq("irq", irq, e_irq);
        o_skip = skip; o_clr = ac_clr; o_or = ac_or; o_strobe = tx_strobe;
        o_irq = irq; o_txdata = tx_data; o_ready = tx_ready;

        // A print completes once the UART has gone busy after the launch and is idle again
        done = m_busy && m_low && tx_ready;
        if (m_busy && cyc > m_launch + 1 && !tx_ready) m_low = 1'b1;
        start = pd && (op == 3'd4 || op == 3'd6);
        if (done) begin
            m_busy = 1'b0;
        end else if (start && !m_busy) begin
            m_busy   = 1'b1;
            m_low    = 1'b0;
            m_launch = cyc;
            m_txdata = s_ac[7:0];
        end
        if (s_rx) begin
            m_kflag = 1'b1;
            m_kbuf  = s_rxd;
        end else if (kd && (op == 3'd0 || op == 3'd2 || op == 3'd6)) begin
            m_kflag = 1'b0;
        end
        if ((pd && op == 3'd0) || done) m_pflag = 1'b1;
        else if (pd && (op == 3'd2 || op == 3'd6)) m_pflag = 1'b0;
        if (IeEn && kd && op == 3'd5) m_ie = s_ac[0];

        if (tx_strobe) begin
            if (rand_frame) frame_len = $urandom_range(1, 12);
            uart_cnt = frame_len;
        end else if (uart_cnt > 0) begin
            uart_cnt--;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 12'o0, 12'o0, 1'b0, 8'h00);
    endtask

    task automatic wait_print_done(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!m_busy) begin
                ok = 1'b1;
                break;
            end
            idle(1);
        end
        check_eq(tag, ok, 1'b1);
    endtask

    initial begin
        int strobes;
        bit seen_low, found;
        model_reset();
        do_reset();

        // Keyboard receive and read
        step(1'b1, 12'o6031, 12'o0, 1'b0, 8'h00);
        check_eq("ksf_empty", o_skip, 1'b0);
        check_eq("irq_empty", o_irq, 1'b0);
        step(1'b0, 12'o0, 12'o0, 1'b1, 8'h41);
        step(1'b1, 12'o6031, 12'o0, 1'b0, 8'h00);
        check_eq("ksf_full", o_skip, 1'b1);
        step(1'b1, 12'o6036, 12'o0, 1'b0, 8'h00);
        check_eq("krb_clr", o_clr, 1'b1);
        check_eq("krb_or", o_or, 12'o0101);
        step(1'b1, 12'o6031, 12'o0, 1'b0, 8'h00);
        check_eq("krb_clears_kflag", o_skip, 1'b0);

        // Receive racing KRB: old byte returned, flag stays set
        step(1'b1, 12'o6036, 12'o0, 1'b1, 8'h55);
        check_eq("race_old_byte", o_or, 12'o0101);
        step(1'b1, 12'o6031, 12'o0, 1'b0, 8'h00);
        check_eq("race_kflag", o_skip, 1'b1);
        step(1'b1, 12'o6034, 12'o0, 1'b0, 8'h00);
        check_eq("race_kbuf", o_or, 12'h055);
        step(1'b1, 12'o6032, 12'o0, 1'b0, 8'h00);

        // Print with a long frame, plus a dropped second print
        frame_len = 100;
        step(1'b1, 12'o6046, 12'o0215, 1'b0, 8'h00);
        step(1'b0, 12'o0, 12'o0, 1'b0, 8'h00);
        check_eq("tls_strobe", o_strobe, 1'b1);
        check_eq("tls_data", o_txdata, 8'h8D);
        step(1'b1, 12'o6044, 12'h033, 1'b0, 8'h00);
        strobes = 0;
        seen_low = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            idle(1);
            if (o_strobe) strobes++;
            if (!o_ready) seen_low = 1'b1;
            if (seen_low && o_ready) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("tx_ready_return", found, 1'b1);
        check_eq("no_second_strobe", strobes, 0);
        check_eq("data_kept", o_txdata, 8'h8D);
        check_eq("pflag_not_early", o_irq, 1'b0);
        step(1'b1, 12'o6041, 12'o0, 1'b0, 8'h00);
        check_eq("tsf_done", o_skip, 1'b1);
        check_eq("irq_pflag", o_irq, 1'b1);
        step(1'b1, 12'o6042, 12'o0, 1'b0, 8'h00);

        // Interrupt enable
        step(1'b1, 12'o6035, 12'o0, 1'b0, 8'h00);
        step(1'b0, 12'o0, 12'o0, 1'b1, 8'h12);
        idle(1);
`ifdef KL8_IE_EN
        check_eq("ie_off_irq", o_irq, 1'b0);
        step(1'b1, 12'o6035, 12'o1, 1'b0, 8'h00);
        idle(1);
        check_eq("ie_on_irq", o_irq, 1'b1);
        step(1'b1, 12'o6045, 12'o0, 1'b0, 8'h00);
        check_eq("tsk_skip", o_skip, 1'b1);
        step(1'b1, 12'o6035, 12'o0, 1'b0, 8'h00);
`else
        check_eq("kie_nop_irq", o_irq, 1'b1);
        step(1'b1, 12'o6045, 12'o0, 1'b0, 8'h00);
        check_eq("tsk_nop", o_skip, 1'b0);
`endif

        // Reset in the middle of a print
        frame_len = 50;
        step(1'b1, 12'o6046, 12'h05A, 1'b0, 8'h00);
        idle(4);
        do_reset();
        step(1'b1, 12'o6031, 12'o0, 1'b0, 8'h00);
        check_eq("rst_kflag", o_skip, 1'b0);
        step(1'b1, 12'o6041, 12'o0, 1'b0, 8'h00);
        check_eq("rst_pflag", o_skip, 1'b0);
        step(1'b0, 12'o0, 12'o0, 1'b1, 8'h77);
        idle(1);
        check_eq("rst_ie", o_irq, 1'b1);
        step(1'b1, 12'o6032, 12'o0, 1'b0, 8'h00);
        idle(60);
        frame_len = 8;
        step(1'b1, 12'o6046, 12'h03C, 1'b0, 8'h00);
        idle(1);
        check_eq("post_rst_strobe", o_strobe, 1'b1);
        check_eq("post_rst_data", o_txdata, 8'h3C);
        wait_print_done("post_rst_done");
        step(1'b1, 12'o6041, 12'o0, 1'b0, 8'h00);
        check_eq("post_rst_pflag", o_skip, 1'b1);

        // Randomized traffic
        rand_frame = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic [5:0]  dev;
            logic [2:0]  rop;
            int          sel;
            sel = $urandom_range(0, 4);
            dev = (sel < 2) ? 6'o03 : (sel < 4) ? 6'o04 : 6'($urandom);
            rop = 3'($urandom);
            step(1'($urandom_range(0, 1)), {3'o6, dev, rop}, 12'($urandom),
                 ($urandom_range(0, 7) == 0), 8'($urandom));
        end
        wait_print_done("final_drain");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
